// File: rtl/eth_tx_fcs_pad.sv
// Zero-pads short frames to MIN_WORDS (when ETH_TX_PAD_EN is defined) and appends the CRC-32 FCS as a 4-byte final beat.
// One-cycle registered latency; s_ready follows the output register (!m_valid || m_ready) and is held low while padding or emitting FCS.
module eth_tx_fcs_pad #(
    parameter int MIN_WORDS = 8
) (
    input  logic        clk156,
    input  logic        rst,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [63:0] m_data,
    output logic [7:0]  m_keep,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic [31:0] frame_count,
    output logic [31:0] pad_word_count
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    if (MIN_WORDS < 1 || MIN_WORDS > 15) begin : g_bad_min_words
        $error("MIN_WORDS must be in 1..15");
    end

`ifdef ETH_TX_PAD_EN
    typedef enum logic [1:0] {PASS, PAD, FCS} state_t;
    localparam logic [3:0] MIN_W = 4'(MIN_WORDS);
`else
    typedef enum logic [1:0] {PASS, FCS} state_t;
`endif

    state_t      state;
    logic [31:0] crc;
    logic [31:0] fcs;
    logic        advance;

    // Reflected CRC over eight bytes, byte [63:56] first, each byte LSB first.
    function automatic logic [31:0] crc64(input logic [31:0] c, input logic [63:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 8; k++) begin
                if (r[0] ^ d[56 - 8*b + k])
                    r = {1'b0, r[31:1]} ^ CRC_POLY;
                else
                    r = {1'b0, r[31:1]};
            end
        end
        return r;
    endfunction

    assign fcs     = ~crc;
    assign advance = !m_valid || m_ready;
    assign s_ready = !rst && (state == PASS) && advance;

`ifdef ETH_TX_PAD_EN
    logic [3:0]  count;
    logic [3:0]  cnt_inc;
    logic        m_pad;
    logic [31:0] pad_cnt;

    assign cnt_inc        = (count == 4'd15) ? 4'd15 : count + 4'd1;
    assign pad_word_count = pad_cnt;
`else
    assign pad_word_count = 32'd0;
`endif

    always_ff @(posedge clk156) begin
        if (rst) begin
            state       <= PASS;
            crc         <= CRC_INIT;
            m_data      <= 64'd0;
            m_keep      <= 8'h00;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            frame_count <= 32'd0;
`ifdef ETH_TX_PAD_EN
            count       <= 4'd0;
            m_pad       <= 1'b0;
            pad_cnt     <= 32'd0;
`endif
        end else begin
            if (m_valid && m_ready && m_last)
                frame_count <= frame_count + 32'd1;
`ifdef ETH_TX_PAD_EN
            if (m_valid && m_ready && m_pad)
                pad_cnt <= pad_cnt + 32'd1;
`endif
            case (state)
                PASS: begin
                    if (s_valid && s_ready) begin
                        m_valid <= 1'b1;
                        m_data  <= s_data;
                        m_keep  <= 8'hFF;
                        m_last  <= 1'b0;
                        crc     <= crc64(crc, s_data);
`ifdef ETH_TX_PAD_EN
                        m_pad   <= 1'b0;
                        count   <= cnt_inc;
                        if (s_last)
                            state <= (cnt_inc >= MIN_W) ? FCS : PAD;
`else
                        if (s_last)
                            state <= FCS;
`endif
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                end
`ifdef ETH_TX_PAD_EN
                PAD: begin
                    if (advance) begin
                        m_valid <= 1'b1;
                        m_data  <= 64'd0;
                        m_keep  <= 8'hFF;
                        m_last  <= 1'b0;
                        m_pad   <= 1'b1;
                        crc     <= crc64(crc, 64'd0);
                        count   <= cnt_inc;
                        if (cnt_inc >= MIN_W)
                            state <= FCS;
                    end
                end
`endif
                FCS: begin
                    if (advance) begin
                        m_valid <= 1'b1;
                        m_data  <= {fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24], 32'd0};
                        m_keep  <= 8'hF0;
                        m_last  <= 1'b1;
                        crc     <= CRC_INIT;
                        state   <= PASS;
`ifdef ETH_TX_PAD_EN
                        m_pad   <= 1'b0;
                        count   <= 4'd0;
`endif
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

endmodule
